fsm_step_arb: RTL and testbench
===============================

# fsm_step_arb

Round-robin arbiter and sequencer for the shared 3-phase stepper FSM (phases IDLE=0, S1=1, S2=2, advanced by a one-cycle `en`). Up to NREQ requesters each ask for the stepper to be driven to a target phase. The block grants one requester at a time, issues `en` pulses, and confirms each advance against the stepper's registered phase output. A watchdog flags a stuck stepper.

## Interface
- NREQ, 4, number of requesters (2..8)
- TIMEOUT, 8, max WAIT cycles per step before error (≥3)
- clk  in  1  clock
- rst_n  in  1  asynchronous active-low reset
- req  in  NREQ  per-requester request level; held until matching `done` bit
- tgt  in  2*NREQ  target phase per requester, bits [2i+1:2i]; valid 0..2
- gnt  out  NREQ  one-hot grant, registered
- done  out  NREQ  one-cycle completion pulse to granted requester
- step_en  out  1  to stepper `en`; one-cycle pulse per advance
- phase_in  in  4  stepper `dout` (registered phase, two cycles behind `en`)
- err  out  1  sticky error flag; cleared only by reset

## Operation
- States: IDLE, CHECK, STEP, WAIT, DONE.
- IDLE: if any req bit is set, select winner round-robin, searching from (last+1) mod NREQ upward. Latch winner index `idx` and tgt slice. Set gnt[idx]. Go to CHECK. Otherwise stay in IDLE.
- CHECK: if latched target = 3 or phase_in > 2, set err and go to DONE. Else if phase_in = target, go to DONE. Else latch expected = (phase_in+1) mod 3 and go to STEP.
- STEP: step_en = 1 for exactly this cycle. Clear watchdog. Go to WAIT.
- WAIT: if phase_in = expected, go to CHECK. Else increment watchdog. When watchdog reaches TIMEOUT-1 without a match, set err and go to DONE.
- DONE: done[idx] = 1 for this cycle. Clear gnt at the end of the cycle. last ← idx. Go to IDLE.
- gnt[idx] is high from CHECK through DONE inclusive. At most one gnt bit and one done bit are set at any time.
- req and tgt are sampled only in IDLE. Dropping req or changing tgt mid-grant has no effect: the operation completes.
- Requests from other requesters wait. A requester still asserting req in the IDLE cycle after its own DONE competes normally; round-robin prevents starvation.
- Stepping is always forward: 0→1→2→0. Wrap-around is a normal path, e.g. 2→0 takes one step.
- After an error DONE, the arbiter continues serving requests. err stays set.
- Reset asserted mid-operation: return immediately to IDLE. Pending operation is abandoned with no done pulse. Stepper resets alongside.

## Timing
- Reset values: gnt=0, done=0, step_en=0, err=0, state=IDLE, last=NREQ-1 (so requester 0 wins first), watchdog=0.
- All outputs are registered or decoded from the registered state only; no combinational path from inputs to outputs.
- Sequence per step: STEP (step_en=1) at cycle t; stepper state updates at edge t+1; phase_in updates at edge t+2. WAIT sees the match at cycle t+2 and CHECK follows at t+3. Nominal cost is 4 cycles per step.
- Latency with req first seen in IDLE at cycle 0 and k steps needed: gnt high from cycle 1, done pulse at cycle 2+4k.
  - k=0: done at cycle 2.
  - k=2: done at cycle 10.
- Back-to-back: after DONE at cycle d, IDLE at d+1 and the next gnt at d+2.

## Test plan
- Reset: hold rst_n=0 with random req/phase_in → gnt=0, done=0, step_en=0, err=0. Release rst_n; first simultaneous req=4'b1111 grants requester 0.
- Single request, stepper at 0, req[1]=1, tgt1=2 → step_en pulses at cycles 2 and 6, done[1] at cycle 10, gnt[1] high cycles 1..10, err=0, stepper ends at 2.
- Already at target, stepper at 1, tgt=1 → no step_en, done at cycle 2. Wrap case, stepper at 2, tgt=0 → one step_en, done at cycle 6.
- Fairness: req=4'b1111 held continuously, all tgt equal to current phase → grants in order 0,1,2,3,0, one grant every 3 cycles, never two gnt bits set.
- Stuck stepper (phase_in forced 0), tgt=1 → one step_en, err rises after TIMEOUT WAIT cycles, done pulses, next request still served. Invalid tgt=3 → no step_en, err=1, done at cycle 2.
- Reset mid-WAIT → outputs return to reset values asynchronously, no done pulse. After release, normal arbitration resumes with requester 0 first.

Source files
------------

// File: rtl/fsm_step_arb.sv
// fsm_step_arb: round-robin arbiter that drives a shared 3-phase stepper
// (0 -> 1 -> 2 -> 0) to each granted requester's target phase. It confirms
// every advance against the stepper's registered phase output, and a watchdog
// raises a sticky error when the stepper stops responding.
module fsm_step_arb #(
    parameter int NREQ    = 4,
    parameter int TIMEOUT = 8
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [NREQ-1:0]   req,
    input  logic [2*NREQ-1:0] tgt,
    output logic [NREQ-1:0]   gnt,
    output logic [NREQ-1:0]   done,
    output logic              step_en,
    input  logic [3:0]        phase_in,
    output logic              err
);

    localparam int IW = (NREQ > 1) ? $clog2(NREQ) : 1;
    localparam int WW = $clog2(TIMEOUT);

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_CHECK = 3'd1,
        S_STEP  = 3'd2,
        S_WAIT  = 3'd3,
        S_DONE  = 3'd4
    } state_t;

    state_t          r_state;
    logic [IW-1:0]   r_last;
    logic [IW-1:0]   r_idx;
    logic [1:0]      r_tgt;
    logic [1:0]      r_exp;
    logic [WW-1:0]   r_wd;

    logic [IW-1:0]   w_c;
    logic [IW-1:0]   w_win;
    logic            w_found;
    logic [1:0]      w_next_ph;
    logic            w_bad;
    logic            w_at_tgt;
    logic            w_at_exp;

    // Round-robin pick: walk from last+1 upward (with wrap); the first set
    // req bit wins.
    always_comb begin
        w_c     = r_last;
        w_win   = r_last;
        w_found = 1'b0;
        for (int i = 0; i < NREQ; i++) begin
            w_c = (w_c == IW'(NREQ - 1)) ? '0 : w_c + 1'b1;
            if (!w_found && req[w_c]) begin
                w_found = 1'b1;
                w_win   = w_c;
            end
        end
    end

    // Phase comparisons against the stepper output. The next phase is only
    // used when phase_in is already known to be valid (0..2).
    always_comb begin
        w_next_ph = (phase_in[1:0] == 2'd2) ? 2'd0 : phase_in[1:0] + 2'd1;
        w_bad     = (r_tgt == 2'd3) || (phase_in > 4'd2);
        w_at_tgt  = (phase_in == {2'b00, r_tgt});
        w_at_exp  = (phase_in == {2'b00, r_exp});
    end

    // Sequencer FSM. All outputs are registered here, so no input reaches an
    // output combinationally.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= S_IDLE;
            r_last  <= IW'(NREQ - 1);
            r_idx   <= '0;
            r_tgt   <= '0;
            r_exp   <= '0;
            r_wd    <= '0;
            gnt     <= '0;
            done    <= '0;
            step_en <= 1'b0;
            err     <= 1'b0;
        end else begin
            step_en <= 1'b0;
            done    <= '0;
            case (r_state)
                S_IDLE: begin
                    if (w_found) begin
                        r_idx   <= w_win;
                        r_tgt   <= tgt[{w_win, 1'b0} +: 2];
                        gnt     <= {{(NREQ-1){1'b0}}, 1'b1} << w_win;
                        r_state <= S_CHECK;
                    end
                end
                S_CHECK: begin
                    if (w_bad) begin
                        err     <= 1'b1;
                        done    <= gnt;
                        r_state <= S_DONE;
                    end else if (w_at_tgt) begin
                        done    <= gnt;
                        r_state <= S_DONE;
                    end else begin
                        r_exp   <= w_next_ph;
                        step_en <= 1'b1;
                        r_state <= S_STEP;
                    end
                end
                S_STEP: begin
                    r_wd    <= '0;
                    r_state <= S_WAIT;
                end
                S_WAIT: begin
                    // The advance shows up on phase_in two cycles after the
                    // en pulse; anything much later means the stepper is stuck.
                    if (w_at_exp) begin
                        r_state <= S_CHECK;
                    end else if (r_wd == WW'(TIMEOUT - 1)) begin
                        err     <= 1'b1;
                        done    <= gnt;
                        r_state <= S_DONE;
                    end else begin
                        r_wd <= r_wd + 1'b1;
                    end
                end
                S_DONE: begin
                    gnt     <= '0;
                    r_last  <= r_idx;
                    r_state <= S_IDLE;
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_fsm_step_arb.sv
// Bench for fsm_step_arb. It uses a behavioural stepper, table vectors,
// hand-written corner sequences and randomized transactions that are checked
// against a round-robin/phase-distance model.
module tb_fsm_step_arb;

    localparam int NREQ    = 4;
    localparam int TIMEOUT = 8;

    logic             clk = 1'b0;
    logic             rst_n = 1'b0;
    logic [NREQ-1:0]  req = '0;
    logic [7:0]       tgt = '0;
    logic [NREQ-1:0]  gnt;
    logic [NREQ-1:0]  done;
    logic             step_en;
    logic [3:0]       phase_in;
    logic             err;

    // Behavioural stepper, with a preload port and a stuck override for tests
    logic [1:0] stp_st;
    logic [3:0] stp_dout;
    logic       ld = 1'b0;
    logic [1:0] ld_val = '0;
    logic       stuck = 1'b0;
    logic [3:0] stuck_val = '0;

    int n_chk = 0;
    int n_pass = 0;

    always #5 clk = ~clk;

    fsm_step_arb #(.NREQ(NREQ), .TIMEOUT(TIMEOUT)) dut (
        .clk(clk), .rst_n(rst_n), .req(req), .tgt(tgt), .gnt(gnt),
        .done(done), .step_en(step_en), .phase_in(phase_in), .err(err)
    );

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            stp_st   <= 2'd0;
            stp_dout <= 4'd0;
        end else if (ld) begin
            stp_st   <= ld_val;
            stp_dout <= {2'b00, ld_val};
        end else begin
            if (step_en) stp_st <= (stp_st == 2'd2) ? 2'd0 : stp_st + 2'd1;
            stp_dout <= {2'b00, stp_st};
        end
    end

    assign phase_in = stuck ? stuck_val : stp_dout;

    task automatic check(input string nm, input int got, input int exp);
        n_chk++;
        if (got == exp) n_pass++;
        else $display("FAIL %s: got %0d expected %0d", nm, got, exp);
    endtask

    // At most one gnt and one done bit at any time
    always @(negedge clk) begin
        if (rst_n) begin
            n_chk++;
            if ($countones(gnt) <= 1 && $countones(done) <= 1) n_pass++;
            else $display("FAIL onehot: gnt=%b done=%b", gnt, done);
        end
    end

    // Preload the stepper while the arbiter is idle
    task automatic preload(input int v);
        ld = 1'b1; ld_val = 2'(v);
        @(posedge clk); #1;
        ld = 1'b0;
    endtask

    // Called mid-cycle in an IDLE cycle (cycle 0). It returns mid-cycle in the
    // IDLE cycle after DONE. Cycle numbers are relative to cycle 0.
    task automatic run_txn(input logic [3:0] r, input logic [7:0] t,
                           input bit scr, input bit hold,
                           output int win, output int dcyc, output int nst,
                           output int fst, output int gcyc, output int ph,
                           output int e);
        req = r; tgt = t;
        win = -1; dcyc = -1; nst = 0; fst = -1; gcyc = -1; ph = -1; e = -1;
        for (int n = 1; n < 48; n++) begin
            @(posedge clk); #1;
            if (gcyc < 0 && gnt != 0) gcyc = n;
            if (step_en) begin
                nst++;
                if (fst < 0) fst = n;
            end
            if (scr && n == 1) begin
                req = 4'($urandom);
                tgt = 8'($urandom);
            end
            if (done != 0) begin
                dcyc = n;
                for (int b = 0; b < NREQ; b++) if (done[b]) win = b;
                ph = int'(phase_in);
                e = int'(err);
                break;
            end
        end
        if (!hold) req = '0;
        @(posedge clk); #1;
    endtask

    function automatic int rr(input logic [3:0] r, input int last);
        for (int i = 1; i <= NREQ; i++)
            if (r[(last + i) % NREQ]) return (last + i) % NREQ;
        return -1;
    endfunction

    typedef struct {
        int ph0;
        int idx;
        int tg;
        int exp_done;
        int exp_steps;
    } vec_t;

    vec_t vt[6];

    initial begin
        int win, dcyc, nst, fst, gcyc, ph, e;
        int mlast, mph, k, tw;
        logic [3:0] r;
        logic [7:0] t;
        logic saw_done;

        vt[0] = '{0, 1, 2, 10, 2};
        vt[1] = '{1, 3, 1,  2, 0};
        vt[2] = '{2, 0, 0,  6, 1};
        vt[3] = '{1, 2, 0, 10, 2};
        vt[4] = '{2, 1, 1, 10, 2};
        vt[5] = '{0, 3, 1,  6, 1};

        // Reset with random activity on the inputs
        req = 4'($urandom); stuck = 1'b1; stuck_val = 4'($urandom);
        repeat (3) @(negedge clk);
        check("rst_gnt", int'(gnt), 0);
        check("rst_done", int'(done), 0);
        check("rst_step_en", int'(step_en), 0);
        check("rst_err", int'(err), 0);
        req = '0; stuck = 1'b0;
        rst_n = 1'b1;
        @(posedge clk); #1;

        // Fairness: all requesting, targets already met
        for (int i = 0; i < 5; i++) begin
            run_txn(4'b1111, 8'h00, 1'b0, i < 4, win, dcyc, nst, fst, gcyc, ph, e);
            check($sformatf("fair_win%0d", i), win, i % NREQ);
            check($sformatf("fair_done%0d", i), dcyc, 2);
            check($sformatf("fair_gnt%0d", i), gcyc, 1);
        end

        // Table vectors: single requester, known starting phase
        for (int i = 0; i < 6; i++) begin
            preload(vt[i].ph0);
            r = 4'(1 << vt[i].idx);
            t = 8'(vt[i].tg << (2 * vt[i].idx));
            run_txn(r, t, 1'b0, 1'b0, win, dcyc, nst, fst, gcyc, ph, e);
            check($sformatf("vec%0d_win", i), win, vt[i].idx);
            check($sformatf("vec%0d_done", i), dcyc, vt[i].exp_done);
            check($sformatf("vec%0d_steps", i), nst, vt[i].exp_steps);
            check($sformatf("vec%0d_phase", i), ph, vt[i].tg);
            check($sformatf("vec%0d_err", i), e, 0);
            if (vt[i].exp_steps > 0) check($sformatf("vec%0d_first_step", i), fst, 2);
        end

        // Randomized transactions against the model
        rst_n = 1'b0; #3; rst_n = 1'b1;
        @(posedge clk); #1;
        mlast = NREQ - 1; mph = 0;
        for (int i = 0; i < 40; i++) begin
            r = 4'($urandom_range(1, 15));
            t = '0;
            for (int b = 0; b < NREQ; b++) t[2*b +: 2] = 2'($urandom_range(0, 2));
            win = rr(r, mlast);
            tw = int'(t[2*win +: 2]);
            k = (tw + 3 - mph) % 3;
            mlast = win; mph = tw;
            run_txn(r, t, ($urandom_range(0, 3) == 0), 1'b0, win, dcyc, nst, fst, gcyc, ph, e);
            check($sformatf("rnd%0d_win", i), win, mlast);
            check($sformatf("rnd%0d_done", i), dcyc, 2 + 4 * k);
            check($sformatf("rnd%0d_steps", i), nst, k);
            check($sformatf("rnd%0d_phase", i), ph, tw);
            check($sformatf("rnd%0d_err", i), e, 0);
        end

        // Stuck stepper: watchdog error, then service continues
        preload(0);
        stuck = 1'b1; stuck_val = 4'd0;
        check("stuck_err_before", int'(err), 0);
        run_txn(4'b0010, 8'b0000_0100, 1'b0, 1'b0, win, dcyc, nst, fst, gcyc, ph, e);
        check("stuck_steps", nst, 1);
        check("stuck_done", dcyc, 3 + TIMEOUT);
        check("stuck_err", e, 1);
        stuck = 1'b0;
        // The real stepper did advance to 1, so 1 -> 2 takes one step
        run_txn(4'b0100, 8'b0010_0000, 1'b0, 1'b0, win, dcyc, nst, fst, gcyc, ph, e);
        check("post_stuck_win", win, 2);
        check("post_stuck_done", dcyc, 6);
        check("post_stuck_phase", ph, 2);
        check("post_stuck_err", e, 1);

        // Invalid target and invalid phase
        rst_n = 1'b0; #3; rst_n = 1'b1;
        @(posedge clk); #1;
        check("inv_err_before", int'(err), 0);
        run_txn(4'b0001, 8'b0000_0011, 1'b0, 1'b0, win, dcyc, nst, fst, gcyc, ph, e);
        check("inv_tgt_done", dcyc, 2);
        check("inv_tgt_steps", nst, 0);
        check("inv_tgt_err", e, 1);
        stuck = 1'b1; stuck_val = 4'd5;
        run_txn(4'b1000, 8'b0100_0000, 1'b0, 1'b0, win, dcyc, nst, fst, gcyc, ph, e);
        check("inv_ph_done", dcyc, 2);
        check("inv_ph_steps", nst, 0);
        stuck = 1'b0;

        // Reset mid-WAIT
        preload(0);
        req = 4'b0100; tgt = 8'b0010_0000;
        repeat (4) @(posedge clk);
        #1;
        check("midwait_gnt", int'(gnt), 4);
        #2 rst_n = 1'b0;
        #1;
        check("midrst_gnt", int'(gnt), 0);
        check("midrst_done", int'(done), 0);
        check("midrst_step_en", int'(step_en), 0);
        check("midrst_err", int'(err), 0);
        req = '0;
        saw_done = 1'b0;
        repeat (3) begin
            @(posedge clk); #1;
            if (done != 0) saw_done = 1'b1;
        end
        check("midrst_no_done", int'(saw_done), 0);
        @(negedge clk) rst_n = 1'b1;
        @(posedge clk); #1;
        run_txn(4'b1111, 8'h00, 1'b0, 1'b0, win, dcyc, nst, fst, gcyc, ph, e);
        check("after_rst_win", win, 0);
        check("after_rst_done", dcyc, 2);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
